// File: rtl/vif_rr_arbiter_if.sv
// Shared producer/consumer channel bundle for the round-robin arbiter.
// The arbiter side uses the slave modport; the surrounding system uses master.
interface vif_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output grant_idx,
    output busy
  );
endinterface

// File: rtl/vif_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ valid/ready producers into one
// registered output slot; a word is held stable until the consumer accepts it.
module vif_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic             clk,
  input logic             rst,
  vif_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    prio_q;
  logic [IDX_W-1:0]    grant_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;

  logic [IDX_W-1:0]    win_d;
  logic [IDX_W-1:0]    prio_d;
  logic                found_d;
  logic                accept_d;
  logic [IDX_W:0]      scan_idx;
  logic [DATA_W-1:0]   lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Scan from prio_q upward with wrap; the one extra bit keeps the sum
  // from overflowing before it is folded back into range.
  always_comb begin
    found_d  = 1'b0;
    win_d    = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, prio_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!found_d && bus.req_valid[scan_idx[IDX_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign prio_d   = (win_d == IDX_W'(NUM_REQ-1)) ? '0 : win_d + IDX_W'(1);
  assign accept_d = !rst && (state_q == IDLE) && found_d;

  assign bus.req_ready = accept_d ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_d)
                                  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            out_data_q  <= lane_data[win_d];
            grant_q     <= win_d;
            prio_q      <= prio_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          // out_data_q intentionally keeps the delivered word
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (state_q == HOLD);
endmodule
